// File: rtl/beta_fetch_unit.sv
// rtl/beta_fetch_unit.sv - Beta instruction fetch and program counter stage
module beta_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h80000000,
  parameter logic [31:0] ILLOP_VEC = 32'h80000004,
  parameter logic [31:0] XADR_VEC  = 32'h80000008
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  pcsel,
  input  logic [31:0] jt,
  input  logic        exec_stall,
  output logic        imem_req,
  output logic [31:0] ia,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic {S_FETCH, S_EXEC} state_t;

  state_t      state, state_nxt;
  logic        req_armed;
  logic        load_instr, load_pc;
  logic [31:0] pc_q, instr_q, next_pc;
  logic [30:0] branch_off, branch_sum;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  // Keeps the fetch request low until the first clock edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) req_armed <= 1'b0;
    else          req_armed <= 1'b1;
  end

  // PC and latched instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_VEC;
      instr_q <= 32'h0;
    end else begin
      if (load_instr) instr_q <= imem_data;
      if (load_pc)    pc_q    <= next_pc;
    end
  end

  // Next-state and handshake decode; ACK only counts while a request is up
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_instr  = 1'b0;
    load_pc     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = req_armed;
        if (req_armed && imem_ack) begin
          load_instr = 1'b1;
          state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (!exec_stall) begin
          load_pc   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
    endcase
  end

  // Branch target wraps inside the 31-bit address space, supervisor bit kept
  always_comb begin
    branch_off = {{13{instr_q[15]}}, instr_q[15:0], 2'b00};
    branch_sum = pc_q[30:0] + 31'd4 + branch_off;
  end

  // Next PC select; JMP can drop but never raise the supervisor bit
  always_comb begin
    next_pc = ILLOP_VEC;
    case (pcsel)
      3'b000:  next_pc = pc_plus4;
      3'b001:  next_pc = {pc_q[31], branch_sum};
      3'b010:  next_pc = {pc_q[31] & jt[31], jt[30:0] & 31'h7FFFFFFC};
      3'b100:  next_pc = XADR_VEC;
      default: next_pc = ILLOP_VEC;
    endcase
  end

  assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
  assign ia       = {pc_q[31:2], 2'b00};
  assign pc       = pc_q;
  assign instr    = instr_q;

endmodule

// File: tb/tb_beta_fetch_unit.sv
// tb/tb_beta_fetch_unit.sv - self-checking bench for beta_fetch_unit
module tb_beta_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  pcsel;
  logic [31:0] jt;
  logic        exec_stall;
  logic        imem_req;
  logic [31:0] ia;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] model_pc;
  logic [31:0] model_instr;

  typedef struct {
    logic [31:0] start;
    logic [31:0] ins;
    logic [2:0]  sel;
    logic [31:0] jtv;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  beta_fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pcsel       (pcsel),
    .jt          (jt),
    .exec_stall  (exec_stall),
    .imem_req    (imem_req),
    .ia          (ia),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Architectural next-PC rule, whole-word arithmetic
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic [2:0] sel, input logic [31:0] j);
    logic [31:0] sup;
    int          off;
    sup = p & 32'h80000000;
    case (sel)
      3'd0: return sup | ((p + 32'd4) & 32'h7FFFFFFF);
      3'd1: begin
        off = $signed(ins[15:0]);
        off = off * 4;
        return sup | ((p + 32'd4 + off) & 32'h7FFFFFFF);
      end
      3'd2: return (j & 32'hFFFFFFFC) & (sup | 32'h7FFFFFFF);
      3'd4: return 32'h80000008;
      default: return 32'h80000004;
    endcase
  endfunction

  task automatic do_reset();
    reset_n    = 1'b0;
    imem_ack   = 1'b0;
    imem_data  = 32'h0;
    exec_stall = 1'b0;
    pcsel      = 3'd0;
    jt         = 32'h0;
    tick();
    tick();
    reset_n     = 1'b1;
    model_pc    = 32'h80000000;
    model_instr = 32'h0;
    #1;
    chk1("req_low_before_first_edge", imem_req, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_instr(input logic [31:0] data, input logic [2:0] sel, input logic [31:0] jtv,
                          input int ack_delay, input int stall);
    int n;
    n = 0;
    while (!imem_req && n < 8) begin
      tick();
      n++;
    end
    chk1("fetch_req", imem_req, 1'b1);
    chk("fetch_ia", ia, model_pc);
    for (int i = 0; i < ack_delay; i++) begin
      imem_ack  = 1'b0;
      imem_data = $urandom;
      tick();
      chk1("wait_req", imem_req, 1'b1);
      chk1("wait_valid", instr_valid, 1'b0);
      chk("wait_instr", instr, model_instr);
    end
    imem_ack  = 1'b1;
    imem_data = data;
    tick();
    imem_ack    = 1'b0;
    model_instr = data;
    chk1("exec_valid", instr_valid, 1'b1);
    chk1("exec_req", imem_req, 1'b0);
    chk("exec_instr", instr, data);
    chk("exec_pc_plus4", pc_plus4, ref_next(model_pc, data, 3'd0, 32'h0));
    pcsel = sel;
    jt    = jtv;
    for (int i = 0; i < stall; i++) begin
      exec_stall = 1'b1;
      imem_ack   = 1'b1;
      imem_data  = ~data;
      tick();
      imem_ack = 1'b0;
      chk("stall_pc", pc, model_pc);
      chk("stall_instr", instr, data);
      chk1("stall_valid", instr_valid, 1'b1);
    end
    exec_stall = 1'b0;
    tick();
    model_pc = ref_next(model_pc, data, sel, jtv);
    chk("next_pc", pc, model_pc);
    chk1("next_valid", instr_valid, 1'b0);
    chk1("next_req", imem_req, 1'b1);
  endtask

  initial begin
    vecs[0]  = '{32'h00000100, 32'h0000FFFE, 3'd1, 32'h0,        32'h000000FC};
    vecs[1]  = '{32'h00000100, 32'h00000003, 3'd1, 32'h0,        32'h00000110};
    vecs[2]  = '{32'h00000040, 32'h0,        3'd2, 32'h80001237, 32'h00001234};
    vecs[3]  = '{32'h80000040, 32'h0,        3'd2, 32'h80001237, 32'h80001234};
    vecs[4]  = '{32'h00000040, 32'h0,        3'd4, 32'h0,        32'h80000008};
    vecs[5]  = '{32'h00000040, 32'h0,        3'd3, 32'h0,        32'h80000004};
    vecs[6]  = '{32'h00000040, 32'h0,        3'd6, 32'h0,        32'h80000004};
    vecs[7]  = '{32'h00000040, 32'h0,        3'd5, 32'h0,        32'h80000004};
    vecs[8]  = '{32'h00000040, 32'h0,        3'd7, 32'h0,        32'h80000004};
    vecs[9]  = '{32'h7FFFFFFC, 32'h0,        3'd0, 32'h0,        32'h00000000};
    vecs[10] = '{32'hFFFFFFFC, 32'h0,        3'd0, 32'h0,        32'h80000000};
    vecs[11] = '{32'h7FFFFFFC, 32'h00000001, 3'd1, 32'h0,        32'h00000004};
    vecs[12] = '{32'h80000000, 32'h00008000, 3'd1, 32'h0,        32'hFFFE0004};

    reset_n    = 1'b0;
    imem_ack   = 1'b0;
    imem_data  = 32'h0;
    exec_stall = 1'b0;
    pcsel      = 3'd0;
    jt         = 32'h0;
    @(negedge clk);
    chk1("reset_req", imem_req, 1'b0);
    chk("reset_pc", pc, 32'h80000000);
    chk("reset_instr", instr, 32'h0);
    chk1("reset_valid", instr_valid, 1'b0);

    // First instruction, ACK on the first request cycle
    do_reset();
    do_instr(32'h80221000, 3'd0, 32'h0, 0, 0);
    chk("first_ia", ia, 32'h80000004);
    chk("first_pc_plus4", pc_plus4, 32'h80000008);

    // Table of PC-select and wrap cases
    for (int v = 0; v < 13; v++) begin
      do_reset();
      do_instr(32'h0, 3'd2, vecs[v].start, 0, 0);
      chk($sformatf("vec%0d_start", v), pc, vecs[v].start);
      do_instr(vecs[v].ins, vecs[v].sel, vecs[v].jtv, 0, 0);
      chk($sformatf("vec%0d_pc", v), pc, vecs[v].exp);
    end

    // Delayed ACK and extended stall
    do_reset();
    do_instr(32'hCAFE0010, 3'd0, 32'h0, 3, 2);
    chk("delay_stall_pc", pc, 32'h80000004);

    // Reset pulse during a fetch with ACK present
    do_reset();
    do_instr(32'hDEADBEEF, 3'd2, 32'h00000200, 0, 0);
    imem_ack  = 1'b1;
    imem_data = 32'h12345678;
    #2;
    reset_n = 1'b0;
    #1;
    chk1("midreset_req", imem_req, 1'b0);
    chk("midreset_pc", pc, 32'h80000000);
    chk("midreset_instr", instr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("midreset_instr_after_edge", instr, 32'h0);
    chk1("midreset_valid", instr_valid, 1'b0);
    imem_ack    = 1'b0;
    reset_n     = 1'b1;
    model_pc    = 32'h80000000;
    model_instr = 32'h0;
    tick();
    chk1("restart_req", imem_req, 1'b1);
    chk("restart_ia", ia, 32'h80000000);
    do_instr(32'h00000001, 3'd0, 32'h0, 0, 0);

    // Randomized instruction stream against the reference model
    for (int k = 0; k < 60; k++) begin
      do_instr($urandom, 3'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/beta_fetch_unit.md
Name: beta_fetch_unit

Overview:
- Instruction-fetch and program-counter stage of the unpipelined Beta core; sits directly upstream of the control unit (CU).
- Holds PC and the supervisor bit (PC[31]), and runs a req/ack handshake with instruction memory.
- Presents the latched instruction to the CU, then advances PC using the CU's PCSEL together with JT and the branch literal.
- Supplies PC+4 to the register-file write-back mux (WDSEL=00).

Parameters:
- RESET_VEC, 32'h80000000, PC loaded on reset.
- ILLOP_VEC, 32'h80000004, PC for PCSEL=011 and undefined PCSEL codes.
- XADR_VEC, 32'h80000008, PC for PCSEL=100 (interrupt).

Ports:
- CLK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- PCSEL  in  3  next-PC select from CU: 000 PC+4, 001 branch, 010 JMP, 011 ILLOP, 100 XAdr
- JT  in  32  jump target (register-file RD1)
- EXEC_STALL  in  1  hold in EXEC (data-memory wait)
- IMEM_REQ  out  1  fetch request
- IA  out  32  instruction address (=PC, bits[1:0]=00)
- IMEM_ACK  in  1  fetch data valid
- IMEM_DATA  in  32  fetched instruction
- INSTR  out  32  latched instruction to CU
- INSTR_VALID  out  1  INSTR is executing this cycle
- PC  out  32  current PC
- PC_PLUS4  out  32  PC+4, supervisor bit preserved

Behaviour:
- Reset (RESET_N=0, asynchronous): state=S_FETCH, PC=RESET_VEC, INSTR=32'h0, INSTR_VALID=0. IMEM_REQ is 0 while reset is asserted and rises on the first CLK edge after deassertion.
- FSM states: S_FETCH, S_EXEC.
- S_FETCH:
  - IMEM_REQ=1, IA=PC, INSTR_VALID=0.
  - On the edge where IMEM_ACK=1: INSTR<=IMEM_DATA, then go to S_EXEC.
  - IMEM_ACK=0: stay; no timeout.
  - Minimum fetch latency is 1 cycle (ACK in the first REQ cycle).
- S_EXEC:
  - IMEM_REQ=0, INSTR_VALID=1; CU decodes INSTR combinationally.
  - EXEC_STALL=1: hold PC, INSTR and state.
  - EXEC_STALL=0: PC<=next_pc, then go to S_FETCH. Each instruction therefore takes at least 2 cycles.
- IMEM_ACK outside S_FETCH is ignored; INSTR does not change.
- next_pc (combinational, evaluated in S_EXEC):
  - 000: PC_PLUS4.
  - 001: {PC[31], (PC+4+(SEXT(INSTR[15:0])<<2))[30:0]}.
  - 010: {PC[31]&JT[31], JT[30:2], 2'b00}. User mode cannot enter supervisor via JMP.
  - 011 and 101/110/111: ILLOP_VEC.
  - 100: XADR_VEC.
- Arithmetic and wrap-around:
  - PC_PLUS4 = {PC[31], PC[30:0]+4} in 31-bit arithmetic, so PC[31] is never altered. 32'h7FFFFFFC -> 32'h00000000; 32'hFFFFFFFC -> 32'h80000000.
  - The branch adder wraps the same way within 31 bits.
- PC[1:0] is always 00. JT[1:0] is discarded.
- PC_PLUS4 is valid in every state; the register file samples it only when WERF is set in S_EXEC.
- Reset mid-fetch: IMEM_REQ drops immediately (asynchronously). An ACK arriving during reset is discarded.
- Simultaneous EXEC_STALL=1 and any PCSEL: the stall wins; PC is unchanged.

Test Plan:
- Reset then ACK on the first REQ cycle with IMEM_DATA=32'h80221000, PCSEL=000 -> IA=32'h80000000, INSTR=32'h80221000, INSTR_VALID high for 1 cycle, then IA=32'h80000004, PC_PLUS4=32'h80000008.
- PC=32'h00000100, INSTR[15:0]=16'hFFFE, PCSEL=001 -> next PC=32'h000000FC. Same case with literal 16'h0003 -> 32'h00000110.
- JMP from user PC=32'h00000040 with JT=32'h80001237 -> PC=32'h00001234. From supervisor PC=32'h80000040 with same JT -> PC=32'h80001234.
- PCSEL=100 -> PC=32'h80000008. PCSEL=011 -> 32'h80000004. PCSEL=110 -> 32'h80000004.
- PC=32'h7FFFFFFC, PCSEL=000 -> PC=32'h00000000. ACK delayed 3 cycles -> IMEM_REQ held 4 cycles and INSTR unchanged until ACK. EXEC_STALL held 2 cycles -> PC held, INSTR_VALID high for 3 cycles.
- RESET_N pulsed low mid-fetch with ACK asserted in the same cycle -> IMEM_REQ low immediately, PC=32'h80000000, INSTR=0, fetch restarts at 32'h80000000.
